// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master data path: state encoding, default word width
// and the bit-ordering helper used by both the transmit and receive directions.
package spi_pkg;

    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    // Word bit that travels as the cnt-th bit on the wire.
    function automatic int unsigned bit_idx(input int unsigned cnt, input logic lsbfe,
                                            input int unsigned data_w);
        return lsbfe ? cnt : (data_w - 1 - cnt);
    endfunction

endpackage

// File: rtl/spi_shifter.sv
// SPI shift stage: serialises the transmit word onto mosi_o and assembles the received
// word from miso_i, stepping on the single-cycle edge flags produced by baud_gen.
module spi_shifter
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              ss_i,
    input  logic              send_data_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              lsbfe_i,
    input  logic [DATA_W-1:0] data_mosi_i,
    input  logic              miso_i,
    input  logic              mosi_send_sclk_i,
    input  logic              mosi_send_sclk0_i,
    input  logic              miso_recieve_sclk_i,
    input  logic              miso_recieve_sclk0_i,
    output logic              mosi_o,
    output logic [DATA_W-1:0] data_miso_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned CW = $clog2(DATA_W) + 1;
    localparam int unsigned IW = $clog2(DATA_W);

    state_e            state_q;
    logic [DATA_W-1:0] tx_shift_q;
    logic [DATA_W-1:0] rx_shift_q;
    logic [CW-1:0]     tx_cnt_q;
    logic [CW-1:0]     rx_cnt_q;
    logic              cpol_q;
    logic              cpha_q;
    logic              lsbfe_q;

    logic              mode_x;
    logic              send_p;
    logic              recv_p;
    logic [IW-1:0]     tx_idx;
    logic [IW-1:0]     rx_idx;
    logic [IW-1:0]     first_idx;
    logic [DATA_W-1:0] rx_word;

    assign mode_x    = cpol_q ^ cpha_q;
    assign send_p    = mode_x ? mosi_send_sclk_i : mosi_send_sclk0_i;
    assign recv_p    = mode_x ? miso_recieve_sclk_i : miso_recieve_sclk0_i;
    assign tx_idx    = IW'(bit_idx(32'(tx_cnt_q), lsbfe_q, DATA_W));
    assign rx_idx    = IW'(bit_idx(32'(rx_cnt_q), lsbfe_q, DATA_W));
    assign first_idx = IW'(bit_idx(32'd0, lsbfe_i, DATA_W));

    // Placing each sample at its final position equals the MSB/LSB-insert shift once the
    // word is complete; rx_word already includes the bit sampled this cycle.
    always_comb begin
        rx_word         = rx_shift_q;
        rx_word[rx_idx] = miso_i;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= StIdle;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            tx_cnt_q    <= '0;
            rx_cnt_q    <= '0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            lsbfe_q     <= 1'b0;
            mosi_o      <= 1'b0;
            data_miso_o <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (send_data_i && !ss_i) begin
                        tx_shift_q <= data_mosi_i;
                        rx_shift_q <= '0;
                        cpol_q     <= cpol_i;
                        cpha_q     <= cpha_i;
                        lsbfe_q    <= lsbfe_i;
                        rx_cnt_q   <= '0;
                        busy_o     <= 1'b1;
                        state_q    <= StShift;
                        // With cpha=0 the first bit must already be on the line before
                        // the first sampling edge.
                        if (!cpha_i) begin
                            mosi_o   <= data_mosi_i[first_idx];
                            tx_cnt_q <= CW'(1);
                        end else begin
                            tx_cnt_q <= '0;
                        end
                    end
                end
                StShift: begin
                    if (ss_i) begin
                        busy_o  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        if (send_p && (tx_cnt_q < CW'(DATA_W))) begin
                            mosi_o   <= tx_shift_q[tx_idx];
                            tx_cnt_q <= tx_cnt_q + CW'(1);
                        end
                        if (recv_p) begin
                            rx_shift_q <= rx_word;
                            rx_cnt_q   <= rx_cnt_q + CW'(1);
                            if (rx_cnt_q == CW'(DATA_W - 1)) begin
                                data_miso_o <= rx_word;
                                done_o      <= 1'b1;
                                state_q     <= StDone;
                            end
                        end
                    end
                end
                StDone: begin
                    busy_o  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_o  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
